// File: rtl/fifo_wc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wc_pkg : default sizing and ratio check for the width FIFO    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package fifo_wc_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int RATIO_DEF      = 2;
   localparam int ADDR_WIDTH_DEF = 4;

   localparam int DEPTH       = 2**ADDR_WIDTH_DEF;
   localparam int WIDE_WIDTH  = RATIO_DEF * DATA_WIDTH_DEF;
   localparam int COUNT_WIDTH = ADDR_WIDTH_DEF + 1;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wc_controller : pointers, occupancy, accept strobes, flags    |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module fifo_wc_controller
   import fifo_wc_pkg::*;
#(
   parameter int RATIO      = RATIO_DEF,
   parameter int ADDR_WIDTH = COUNT_WIDTH - 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clear_i,
   input  logic                  write_i,
   input  logic                  read_i,
   output logic                  wr_en_o,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] wr_ptr_o,
   output logic [ADDR_WIDTH-1:0] rd_ptr_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int C_DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   C_RATIO_CNT = (ADDR_WIDTH+1)'(RATIO);
   localparam logic [ADDR_WIDTH-1:0] C_RATIO_PTR = ADDR_WIDTH'(RATIO);
   localparam logic [ADDR_WIDTH:0]   C_FULL_AT   = (ADDR_WIDTH+1)'(C_DEPTH - RATIO);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_acc, rd_acc;

   // Acceptance uses only pre-edge occupancy, so a same-cycle read never frees room for a write.
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q > C_FULL_AT);
   assign wr_acc  = write_i & ~full_o;
   assign rd_acc  = read_i & ~empty_o;

   assign wr_en_o     = wr_acc & ~reset_i & ~clear_i;
   assign rd_en_o     = rd_acc & ~reset_i & ~clear_i;
   assign wr_ptr_o    = wr_ptr_q;
   assign rd_ptr_o    = rd_ptr_q;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (write_i & full_o);
      udf_d    = udf_q | (read_i & empty_o);
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + C_RATIO_PTR;
         count_d  = count_d + C_RATIO_CNT;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         count_d  = count_d - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_width_converter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_width_converter : write-wide / read-narrow FIFO with storage  |
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
module fifo_width_converter
   import fifo_wc_pkg::*;
#(
   parameter int DATA_WIDTH = WIDE_WIDTH / RATIO_DEF,
   parameter int RATIO      = RATIO_DEF,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        clear_i,
   input  logic                        write_i,
   input  logic [RATIO*DATA_WIDTH-1:0] write_data_i,
   input  logic                        read_i,
   output logic [DATA_WIDTH-1:0]       read_data_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [ADDR_WIDTH:0]         count_o,
   output logic                        overflow_o,
   output logic                        underflow_o
);

   localparam int C_DEPTH = 2**ADDR_WIDTH;

   if (!is_pow2(RATIO) || (RATIO < 2) || (RATIO > C_DEPTH)) begin : g_bad_ratio
      $error("fifo_width_converter: RATIO must be a power of two in 2..2**ADDR_WIDTH");
   end

   logic                  wr_en, rd_en;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];

   fifo_wc_controller #(
      .RATIO      (RATIO),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ctrl (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear_i),
      .write_i     (write_i),
      .read_i      (read_i),
      .wr_en_o     (wr_en),
      .rd_en_o     (rd_en),
      .wr_ptr_o    (wr_ptr),
      .rd_ptr_o    (rd_ptr),
      .count_o     (count_o),
      .empty_o     (empty_o),
      .full_o      (full_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o)
   );

   // Lane k lands at wr_ptr+k; the addition wraps naturally at the array size.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < RATIO; k++) begin
            mem_q[wr_ptr + ADDR_WIDTH'(k)] <= write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign read_data_o = mem_q[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fifo_width_converter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_width_converter : randomized + directed scoreboard bench   |
// | Revision                : 1.0                                      |
// +--------------------------------------------------------------------+
module tb_fifo_width_converter;

   localparam int DW    = 8;
   localparam int RATIO = 2;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          clear_i = 1'b0;
   logic          write_i = 1'b0;
   logic [15:0]   write_data_i = '0;
   logic          read_i = 1'b0;
   logic [7:0]    read_data_o;
   logic          empty_o, full_o, overflow_o, underflow_o;
   logic [4:0]    count_o;

   int errors = 0;
   int checks = 0;

   // Reference model: occupancy as an integer, data as a byte queue.
   int         cur_cnt = 0, nxt_cnt = 0;
   bit         cur_ovf = 0, nxt_ovf = 0;
   bit         cur_udf = 0, nxt_udf = 0;
   logic [7:0] exp_q [$];

   fifo_width_converter #(.DATA_WIDTH(DW), .RATIO(RATIO), .ADDR_WIDTH(4)) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .clear_i      (clear_i),
      .write_i      (write_i),
      .write_data_i (write_data_i),
      .read_i       (read_i),
      .read_data_o  (read_data_o),
      .empty_o      (empty_o),
      .full_o       (full_o),
      .count_o      (count_o),
      .overflow_o   (overflow_o),
      .underflow_o  (underflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step(input bit w, input logic [15:0] d, input bit r, input bit c, input bit rs);
      bit wacc, racc;
      @(posedge clk);
      #1;
      cur_cnt = nxt_cnt;
      cur_ovf = nxt_ovf;
      cur_udf = nxt_udf;
      write_i      = w;
      write_data_i = d;
      read_i       = r;
      clear_i      = c;
      reset_i      = rs;
      if (rs || c) begin
         nxt_cnt = 0;
         nxt_ovf = 0;
         nxt_udf = 0;
         exp_q.delete();
      end else begin
         wacc = w && ((DEPTH - cur_cnt) >= RATIO);
         racc = r && (cur_cnt > 0);
         if (w && !wacc) nxt_ovf = 1;
         if (r && !racc) nxt_udf = 1;
         if (wacc) begin
            exp_q.push_back(d[7:0]);
            exp_q.push_back(d[15:8]);
         end
         nxt_cnt = cur_cnt + (wacc ? RATIO : 0) - (racc ? 1 : 0);
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      chk("count", 32'(count_o), 32'(cur_cnt));
      chk("empty", 32'(empty_o), 32'(cur_cnt == 0));
      chk("full", 32'(full_o), 32'((DEPTH - cur_cnt) < RATIO));
      chk("overflow", 32'(overflow_o), 32'(cur_ovf));
      chk("underflow", 32'(underflow_o), 32'(cur_udf));
      if (!reset_i && !clear_i && read_i && !empty_o) begin
         if (exp_q.size() == 0) begin
            chk("rdata_unexpected", 32'(read_data_o), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rdata", 32'(read_data_o), 32'(e));
         end
      end
   end

   initial begin
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      repeat (2) step(0, '0, 0, 0, 0);
      step(0, '0, 1, 0, 0);                 // read while empty
      repeat (2) step(0, '0, 0, 0, 0);

      step(0, '0, 0, 1, 0);
      step(1, 16'hBEEF, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 0);

      for (int i = 0; i < 9; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
      step(0, '0, 0, 0, 0);
      for (int i = 0; i < 17; i++) step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 0);

      for (int i = 0; i < 3; i++) step(1, 16'hA000 + 16'(i), 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 16'hC300 + 16'(i * 17), 0, 0, 0);
      for (int i = 0; i < 15; i++) step(0, '0, 1, 0, 0);

      step(0, '0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(1, 16'h5500 + 16'(i), 0, 0, 0);
      step(0, '0, 1, 0, 0);                 // count 15
      step(1, 16'hDEAD, 1, 0, 0);           // read accepted, write rejected
      for (int i = 0; i < 15; i++) step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 0);
      step(1, 16'h1122, 0, 0, 0);
      step(1, 16'h3344, 0, 0, 0);
      step(1, 16'h5566, 1, 0, 0);           // count 4 -> 5
      for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 0);

      for (int i = 0; i < 3; i++) step(1, 16'h7700 + 16'(i), 0, 0, 0);
      step(0, '0, 0, 1, 0);
      step(1, 16'h1234, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 0);

      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 99) < 45, 16'($urandom), $urandom_range(0, 99) < 50,
              $urandom_range(0, 199) < 2, $urandom_range(0, 399) < 1);
      end
      for (int i = 0; i < 18; i++) step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_width_converter.md
# fifo_width_converter

Parametrised synchronous FIFO with integrated storage that accepts one wide word per write and returns it as RATIO narrow words, lowest lane first. It is the next generation of the two-pointer write-wide/read-narrow FIFO controller. It generalises the conversion ratio, tracks true occupancy, handles simultaneous read/write correctly in all states, and adds flush and sticky error flags. It sits between a wide producer (e.g. a 16-bit sample packer) and a narrow consumer (e.g. UART TX byte path).

## Interface
- DATA_WIDTH, 8: narrow (read-side) word width in bits.
- RATIO, 2: narrow words per write; power of two, 2 ≤ RATIO ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, 4: depth is 2**ADDR_WIDTH narrow entries.

- clk_i  input  1  single clock; all state changes on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous flush; empties FIFO, clears error flags.
- write_i  input  1  write request for one wide word.
- write_data_i  input  RATIO*DATA_WIDTH  wide word; lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- read_i  input  1  read (pop) request for one narrow word.
- read_data_o  output  DATA_WIDTH  head entry, first-word-fall-through; undefined-but-stable when empty.
- empty_o  output  1  count == 0.
- full_o  output  1  free entries < RATIO (a wide write would not fit).
- count_o  output  ADDR_WIDTH+1  narrow entries stored, 0..2**ADDR_WIDTH.
- overflow_o  output  1  sticky: write_i asserted while full_o.
- underflow_o  output  1  sticky: read_i asserted while empty_o.

## Operation
- Storage: flop array of 2**ADDR_WIDTH × DATA_WIDTH. Write pointer advances by RATIO and read pointer by 1, both modulo 2**ADDR_WIDTH (natural wrap).
- Accepted write (write_i & ~full_o): lane k goes to mem[wp+k] for k = 0..RATIO-1; wp += RATIO.
- Accepted read (read_i & ~empty_o): rp += 1; read_data_o then shows mem[rp+1].
- Acceptance is judged on pre-edge state only. A read does not free space for a same-cycle write, and a write does not make data readable by a same-cycle read.
- count_next = count + (wr_acc ? RATIO : 0) − (rd_acc ? 1 : 0). empty_o and full_o are derived from the registered count.
- Rejected requests leave pointers, memory and count unchanged. They set overflow_o or underflow_o, which stay set until reset or clear.
- Priority: reset_i > clear_i > normal operation. clear_i zeroes pointers, count and flags. Memory contents are not cleared.

## Timing
- Reset values: count_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0; pointers 0.
- Write latency: data written at edge N is visible on read_data_o after edge N, and empty_o falls at the same edge.
- Read: read_data_o is valid combinationally while ~empty_o. Asserting read_i consumes it at the next edge.
- Flag updates are registered (1-cycle). Flags and count change only on edges.
- Simultaneous accepted write and read: count changes by RATIO−1. When full_o=1 with count = 2**ADDR_WIDTH − RATIO + 1, the read is accepted, the write is rejected and overflow_o is set.
- Reset or clear mid-stream discards all queued data at that edge. The next cycle behaves as post-reset.

## Structure
- Package fifo_wc_pkg: localparams DEPTH = 2**ADDR_WIDTH, WIDE_WIDTH = RATIO*DATA_WIDTH, COUNT_WIDTH = ADDR_WIDTH+1, plus a function checking that RATIO is a power of two (elaboration-time assertion).
- Sub-module fifo_wc_controller: pointers, count, flags, and the accept signals wr_en and rd_en.
- The top instantiates the controller and holds the memory array and lane-scatter write logic.

## Test plan
- Reset then idle: count_o=0, empty_o=1, full_o=0, both error flags 0. read_i with empty_o=1 sets underflow_o=1 and count stays 0.
- Write 16'hBEEF (RATIO=2, DATA_WIDTH=8) → count_o=2. Reads return 8'hEF then 8'hBE; empty_o=1 after the second read.
- Depth 16, 8 writes of 16'h0100+i → full_o=1 at count 16. A 9th write sets overflow_o, count stays 16, and the data is unchanged on drain.
- Wrap: 3 writes, 6 reads, then 7 writes (pointers cross 15→0) → all 14 bytes drain in order, with no loss.
- count 15 (full_o=1), write_i and read_i together → read accepted, write rejected, count 14, overflow_o=1. The same case at count 4 gives count 5.
- After 3 writes, assert clear_i → count 0, empty_o=1, flags 0. A following write/read of 16'h1234 returns 8'h34, 8'h12.
